// File: rtl/tlb_mmu.sv
// tlb_mmu: 32-entry fully-associative MIPS32 joint TLB with CP0 TLBWI/TLBP/TLBR
// access and registered fetch/data address translation.
module tlb_mmu #(
   parameter int IDX_W = 5
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        tlbwi,
   input  logic        tlbp,
   input  logic        tlbr,
   input  logic [31:0] index_r2t,
   input  logic [31:0] entryhi_r2t,
   input  logic [31:0] entrylo0_r2t,
   input  logic [31:0] entrylo1_r2t,
   input  logic [31:0] pagemask_r2t,
   output logic [31:0] index_t2r,
   output logic [31:0] entryhi_t2r,
   output logic [31:0] entrylo0_t2r,
   output logic [31:0] entrylo1_t2r,
   output logic [31:0] pagemask_t2r,
   input  logic        inst_req,
   input  logic [31:0] inst_vaddr,
   output logic        inst_valid,
   output logic [31:0] inst_paddr,
   output logic        inst_refill,
   output logic        inst_invalid,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [31:0] data_vaddr,
   output logic        data_valid,
   output logic [31:0] data_paddr,
   output logic        data_refill,
   output logic        data_invalid,
   output logic        data_modified
);
   localparam int N = 1 << IDX_W;

   typedef struct packed {
      logic [18:0] vpn2;
      logic [7:0]  asid;
      logic        g;
      logic [11:0] mask;
      logic [19:0] pfn0;
      logic [2:0]  c0;
      logic        d0;
      logic        v0;
      logic [19:0] pfn1;
      logic [2:0]  c1;
      logic        d1;
      logic        v1;
   } entry_t;

   entry_t tlb_q [N];
   entry_t wr_e, rd_e, ie, de;
   logic [IDX_W-1:0] widx, pidx, iidx, didx;
   logic [N-1:0] hit_p, hit_i, hit_d;
   logic [7:0] asid;
   logic iunm, dunm, ipg, dpg, iv, dv, dd;
   logic [19:0] ipfn, dpfn;
   logic [31:0] inst_paddr_d, data_paddr_d;
   logic inst_refill_d, inst_invalid_d, data_refill_d, data_invalid_d, data_modified_d;
   logic inst_valid_q, inst_refill_q, inst_invalid_q;
   logic data_valid_q, data_refill_q, data_invalid_q, data_modified_q;
   logic [31:0] inst_paddr_q, data_paddr_q;
   logic unused_bits;

   assign unused_bits = ^{index_r2t[31:IDX_W], entryhi_r2t[12:8], entrylo0_r2t[31:26],
                          entrylo1_r2t[31:26], pagemask_r2t[31:25], pagemask_r2t[12:0]};

   assign widx = index_r2t[IDX_W-1:0];
   assign asid = entryhi_r2t[7:0];

   always_comb begin
      wr_e      = '0;
      wr_e.vpn2 = entryhi_r2t[31:13];
      wr_e.asid = entryhi_r2t[7:0];
      wr_e.g    = entrylo0_r2t[0] & entrylo1_r2t[0];
      wr_e.mask = pagemask_r2t[24:13];
      wr_e.pfn0 = entrylo0_r2t[25:6];
      wr_e.c0   = entrylo0_r2t[5:3];
      wr_e.d0   = entrylo0_r2t[2];
      wr_e.v0   = entrylo0_r2t[1];
      wr_e.pfn1 = entrylo1_r2t[25:6];
      wr_e.c1   = entrylo1_r2t[5:3];
      wr_e.d1   = entrylo1_r2t[2];
      wr_e.v1   = entrylo1_r2t[1];
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < N; i++) tlb_q[i] <= '0;
      end else if (tlbwi) begin
         tlb_q[widx] <= wr_e;
      end
   end

   // Page size is fixed at 4KB, so the stored mask never takes part in matching.
   for (genvar k = 0; k < N; k++) begin : g_match
      assign hit_p[k] = tlb_q[k].vpn2 == entryhi_r2t[31:13] && (tlb_q[k].g || tlb_q[k].asid == asid);
      assign hit_i[k] = tlb_q[k].vpn2 == inst_vaddr[31:13] && (tlb_q[k].g || tlb_q[k].asid == asid);
      assign hit_d[k] = tlb_q[k].vpn2 == data_vaddr[31:13] && (tlb_q[k].g || tlb_q[k].asid == asid);
   end

   function automatic logic [IDX_W-1:0] first_set(input logic [N-1:0] v);
      first_set = '0;
      for (int i = N - 1; i >= 0; i--) if (v[i]) first_set = i[IDX_W-1:0];
   endfunction

   assign pidx = first_set(hit_p);
   assign iidx = first_set(hit_i);
   assign didx = first_set(hit_d);
   assign rd_e = tlb_q[widx];
   assign ie   = tlb_q[iidx];
   assign de   = tlb_q[didx];

   assign index_t2r    = !tlbp ? '0 : |hit_p ? {{(32-IDX_W){1'b0}}, pidx} : 32'h8000_0000;
   assign entryhi_t2r  = tlbr ? {rd_e.vpn2, 5'b0, rd_e.asid} : '0;
   assign entrylo0_t2r = tlbr ? {6'b0, rd_e.pfn0, rd_e.c0, rd_e.d0, rd_e.v0, rd_e.g} : '0;
   assign entrylo1_t2r = tlbr ? {6'b0, rd_e.pfn1, rd_e.c1, rd_e.d1, rd_e.v1, rd_e.g} : '0;
   assign pagemask_t2r = tlbr ? {7'b0, rd_e.mask, 13'b0} : '0;

   always_comb begin
      iunm            = inst_vaddr[31:30] == 2'b10;
      ipg             = inst_vaddr[12];
      ipfn            = ipg ? ie.pfn1 : ie.pfn0;
      iv              = ipg ? ie.v1 : ie.v0;
      inst_paddr_d    = iunm ? {3'b0, inst_vaddr[28:0]} : {ipfn, inst_vaddr[11:0]};
      inst_refill_d   = !iunm && !(|hit_i);
      inst_invalid_d  = !iunm && |hit_i && !iv;
      dunm            = data_vaddr[31:30] == 2'b10;
      dpg             = data_vaddr[12];
      dpfn            = dpg ? de.pfn1 : de.pfn0;
      dv              = dpg ? de.v1 : de.v0;
      dd              = dpg ? de.d1 : de.d0;
      data_paddr_d    = dunm ? {3'b0, data_vaddr[28:0]} : {dpfn, data_vaddr[11:0]};
      data_refill_d   = !dunm && !(|hit_d);
      data_invalid_d  = !dunm && |hit_d && !dv;
      data_modified_d = !dunm && |hit_d && dv && !dd && data_wr;
   end

   // Result fields hold their last value when no request is made.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         inst_valid_q    <= 1'b0;
         inst_paddr_q    <= '0;
         inst_refill_q   <= 1'b0;
         inst_invalid_q  <= 1'b0;
         data_valid_q    <= 1'b0;
         data_paddr_q    <= '0;
         data_refill_q   <= 1'b0;
         data_invalid_q  <= 1'b0;
         data_modified_q <= 1'b0;
      end else begin
         inst_valid_q <= inst_req;
         data_valid_q <= data_req;
         if (inst_req) begin
            inst_paddr_q   <= inst_paddr_d;
            inst_refill_q  <= inst_refill_d;
            inst_invalid_q <= inst_invalid_d;
         end
         if (data_req) begin
            data_paddr_q    <= data_paddr_d;
            data_refill_q   <= data_refill_d;
            data_invalid_q  <= data_invalid_d;
            data_modified_q <= data_modified_d;
         end
      end
   end

   assign inst_valid    = inst_valid_q;
   assign inst_paddr    = inst_paddr_q;
   assign inst_refill   = inst_refill_q;
   assign inst_invalid  = inst_invalid_q;
   assign data_valid    = data_valid_q;
   assign data_paddr    = data_paddr_q;
   assign data_refill   = data_refill_q;
   assign data_invalid  = data_invalid_q;
   assign data_modified = data_modified_q;
endmodule

// File: tb/tb_tlb_mmu.sv
// tb_tlb_mmu: directed self-checking bench for tlb_mmu covering CP0 access,
// both translation ports, exception classes and reset behaviour.
module tb_tlb_mmu;
   logic        clk = 1'b0;
   logic        resetn;
   logic        tlbwi, tlbp, tlbr;
   logic [31:0] index_r2t, entryhi_r2t, entrylo0_r2t, entrylo1_r2t, pagemask_r2t;
   logic [31:0] index_t2r, entryhi_t2r, entrylo0_t2r, entrylo1_t2r, pagemask_t2r;
   logic        inst_req, inst_valid, inst_refill, inst_invalid;
   logic [31:0] inst_vaddr, inst_paddr;
   logic        data_req, data_wr, data_valid, data_refill, data_invalid, data_modified;
   logic [31:0] data_vaddr, data_paddr;
   int checks = 0;
   int errors = 0;

   tlb_mmu dut (
      .clk(clk), .resetn(resetn),
      .tlbwi(tlbwi), .tlbp(tlbp), .tlbr(tlbr),
      .index_r2t(index_r2t), .entryhi_r2t(entryhi_r2t), .entrylo0_r2t(entrylo0_r2t),
      .entrylo1_r2t(entrylo1_r2t), .pagemask_r2t(pagemask_r2t),
      .index_t2r(index_t2r), .entryhi_t2r(entryhi_t2r), .entrylo0_t2r(entrylo0_t2r),
      .entrylo1_t2r(entrylo1_t2r), .pagemask_t2r(pagemask_t2r),
      .inst_req(inst_req), .inst_vaddr(inst_vaddr), .inst_valid(inst_valid),
      .inst_paddr(inst_paddr), .inst_refill(inst_refill), .inst_invalid(inst_invalid),
      .data_req(data_req), .data_wr(data_wr), .data_vaddr(data_vaddr),
      .data_valid(data_valid), .data_paddr(data_paddr), .data_refill(data_refill),
      .data_invalid(data_invalid), .data_modified(data_modified)
   );

   always #5 clk = ~clk;

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] idx, eh, lo0, lo1, pm);
      index_r2t = idx; entryhi_r2t = eh; entrylo0_r2t = lo0; entrylo1_r2t = lo1;
      pagemask_r2t = pm; tlbwi = 1'b1;
      cyc();
      tlbwi = 1'b0;
   endtask

   task automatic test_reset;
      resetn = 1'b0;
      tlbwi = 0; tlbp = 0; tlbr = 0; index_r2t = 0; entryhi_r2t = 0;
      entrylo0_r2t = 0; entrylo1_r2t = 0; pagemask_r2t = 0;
      inst_req = 0; inst_vaddr = 0; data_req = 0; data_wr = 0; data_vaddr = 0;
      cyc(); cyc();
      checks++;
      if ({inst_valid, inst_refill, inst_invalid, inst_paddr} !== 35'b0) begin
         errors++; $display("FAIL reset_inst got %b/%b/%b/%h exp 0", inst_valid, inst_refill, inst_invalid, inst_paddr);
      end
      checks++;
      if ({data_valid, data_refill, data_invalid, data_modified, data_paddr} !== 36'b0) begin
         errors++; $display("FAIL reset_data got %b/%b/%b/%b/%h exp 0", data_valid, data_refill, data_invalid, data_modified, data_paddr);
      end
      resetn = 1'b1;
      cyc();
   endtask

   task automatic test_empty;
      inst_req = 1; inst_vaddr = 32'h0040_0000;
      data_req = 1; data_vaddr = 32'hBFC0_0000;
      cyc();
      checks++;
      if ({inst_valid, inst_refill, inst_invalid} !== 3'b110) begin
         errors++; $display("FAIL empty_refill got v/r/i=%b%b%b exp 110", inst_valid, inst_refill, inst_invalid);
      end
      checks++;
      if ({data_valid, data_refill, data_invalid, data_modified, data_paddr} !== {4'b1000, 32'h1FC0_0000}) begin
         errors++; $display("FAIL unmapped_kseg1 got %b%b%b%b %h exp 1000 1fc00000", data_valid, data_refill, data_invalid, data_modified, data_paddr);
      end
      inst_vaddr = 32'h8000_1234;
      data_req = 0;
      cyc();
      checks++;
      if ({inst_valid, inst_refill, inst_paddr} !== {2'b10, 32'h0000_1234}) begin
         errors++; $display("FAIL unmapped_kseg0 got %b%b %h exp 10 00001234", inst_valid, inst_refill, inst_paddr);
      end
      checks++;
      if ({data_valid, data_paddr} !== {1'b0, 32'h1FC0_0000}) begin
         errors++; $display("FAIL data_hold got %b %h exp 0 1fc00000", data_valid, data_paddr);
      end
      inst_req = 0;
      cyc();
      checks++;
      if ({inst_valid, inst_paddr} !== {1'b0, 32'h0000_1234}) begin
         errors++; $display("FAIL inst_hold got %b %h exp 0 00001234", inst_valid, inst_paddr);
      end
   endtask

   task automatic test_translate;
      data_req = 1; data_wr = 0; data_vaddr = 32'h0040_0123;
      index_r2t = 32'h0000_00E3; entryhi_r2t = 32'h0040_0005;
      entrylo0_r2t = 32'h0000_1006; entrylo1_r2t = 0; pagemask_r2t = 0; tlbwi = 1;
      cyc();
      tlbwi = 0;
      checks++;
      if ({data_valid, data_refill} !== 2'b11) begin
         errors++; $display("FAIL write_same_edge got v/r=%b%b exp 11", data_valid, data_refill);
      end
      cyc();
      checks++;
      if ({data_valid, data_refill, data_invalid, data_modified, data_paddr} !== {4'b1000, 32'h0004_0123}) begin
         errors++; $display("FAIL load_hit got %b%b%b%b %h exp 1000 00040123", data_valid, data_refill, data_invalid, data_modified, data_paddr);
      end
      entryhi_r2t = 32'h0040_0006;
      cyc();
      checks++;
      if ({data_valid, data_refill, data_invalid} !== 3'b110) begin
         errors++; $display("FAIL asid_mismatch got %b%b%b exp 110", data_valid, data_refill, data_invalid);
      end
      entryhi_r2t = 32'h0040_0005; data_vaddr = 32'h0040_1000;
      cyc();
      checks++;
      if ({data_valid, data_refill, data_invalid, data_modified} !== 4'b1010) begin
         errors++; $display("FAIL odd_page_invalid got %b%b%b%b exp 1010", data_valid, data_refill, data_invalid, data_modified);
      end
      data_req = 0;
      wr(32'd3, 32'h0040_0005, 32'h0000_1002, 32'h0, 32'h0001_E000);
      data_req = 1; data_wr = 1; data_vaddr = 32'h0040_0010;
      cyc();
      checks++;
      if ({data_valid, data_refill, data_invalid, data_modified} !== 4'b1001) begin
         errors++; $display("FAIL store_modified got %b%b%b%b exp 1001", data_valid, data_refill, data_invalid, data_modified);
      end
      data_wr = 0;
      cyc();
      checks++;
      if ({data_modified, data_paddr} !== {1'b0, 32'h0004_0010}) begin
         errors++; $display("FAIL load_clean got %b %h exp 0 00040010", data_modified, data_paddr);
      end
      data_req = 0;
   endtask

   task automatic test_probe;
      tlbp = 1; entryhi_r2t = 32'h0040_0005;
      #1;
      checks++;
      if (index_t2r !== 32'd3) begin
         errors++; $display("FAIL probe_hit got %h exp 00000003", index_t2r);
      end
      entryhi_r2t = 32'h7000_0000;
      #1;
      checks++;
      if (index_t2r !== 32'h8000_0000) begin
         errors++; $display("FAIL probe_miss got %h exp 80000000", index_t2r);
      end
      tlbp = 0;
      wr(32'd1, 32'h0040_0005, 32'h0000_1006, 32'h0, 32'h0);
      tlbp = 1; entryhi_r2t = 32'h0040_0005;
      #1;
      checks++;
      if (index_t2r !== 32'd1) begin
         errors++; $display("FAIL probe_dup got %h exp 00000001", index_t2r);
      end
      tlbp = 0;
      wr(32'd7, 32'h1234_0009, 32'h0000_1003, 32'h0000_0001, 32'h0);
      tlbp = 1; entryhi_r2t = 32'h1234_0002;
      inst_req = 1; inst_vaddr = 32'h1234_0ABC;
      #1;
      checks++;
      if (index_t2r !== 32'd7) begin
         errors++; $display("FAIL probe_global got %h exp 00000007", index_t2r);
      end
      cyc();
      tlbp = 0; inst_req = 0;
      checks++;
      if ({inst_valid, inst_refill, inst_invalid, inst_paddr} !== {3'b100, 32'h0004_0ABC}) begin
         errors++; $display("FAIL inst_global got %b%b%b %h exp 100 00040abc", inst_valid, inst_refill, inst_invalid, inst_paddr);
      end
   endtask

   task automatic test_read;
      tlbr = 1; index_r2t = 32'd3;
      #1;
      checks++;
      if ({entryhi_t2r, entrylo0_t2r, entrylo1_t2r, pagemask_t2r} !== {32'h0040_0005, 32'h0000_1002, 32'h0, 32'h0001_E000}) begin
         errors++; $display("FAIL tlbr_idx3 got %h %h %h %h exp 00400005 00001002 00000000 0001e000", entryhi_t2r, entrylo0_t2r, entrylo1_t2r, pagemask_t2r);
      end
      index_r2t = 32'd7;
      #1;
      checks++;
      if ({entryhi_t2r, entrylo0_t2r, entrylo1_t2r} !== {32'h1234_0009, 32'h0000_1003, 32'h0000_0001}) begin
         errors++; $display("FAIL tlbr_idx7 got %h %h %h exp 12340009 00001003 00000001", entryhi_t2r, entrylo0_t2r, entrylo1_t2r);
      end
      tlbr = 0;
      cyc();
   endtask

   task automatic test_reset_mid;
      data_req = 1; data_vaddr = 32'h0040_0123; inst_req = 1; inst_vaddr = 32'h8000_0000;
      cyc();
      checks++;
      if ({inst_valid, data_valid} !== 2'b11) begin
         errors++; $display("FAIL pre_reset_valid got %b%b exp 11", inst_valid, data_valid);
      end
      #2 resetn = 0;
      #1;
      checks++;
      if ({inst_valid, data_valid, data_paddr} !== 34'b0) begin
         errors++; $display("FAIL reset_mid got %b%b %h exp 00 00000000", inst_valid, data_valid, data_paddr);
      end
      cyc();
      checks++;
      if ({inst_valid, data_valid} !== 2'b00) begin
         errors++; $display("FAIL reset_hold got %b%b exp 00", inst_valid, data_valid);
      end
      resetn = 1; data_req = 0; inst_req = 0;
      tlbp = 1; entryhi_r2t = 32'h0040_0005;
      #1;
      checks++;
      if (index_t2r !== 32'h8000_0000) begin
         errors++; $display("FAIL reset_clears_tlb got %h exp 80000000", index_t2r);
      end
      tlbp = 0;
      cyc();
   endtask

   initial begin
      test_reset();
      test_empty();
      test_translate();
      test_probe();
      test_read();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
